// File: rtl/bound_stream_reducer.sv
// Folds per-beat lower/upper candidates into the tightest interval over a frame.
// The interval is then held for the consumer behind a valid/ready handshake.
module bound_stream_reducer #(
    parameter int NUMBER_SIZE = 4,
    parameter int COUNT_SIZE  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [NUMBER_SIZE-1:0] lower_candidate,
    input  logic                   lower_activation,
    input  logic [NUMBER_SIZE-1:0] upper_candidate,
    input  logic                   upper_activation,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUMBER_SIZE-1:0] lower_bound,
    output logic                   lower_bound_activation,
    output logic [NUMBER_SIZE-1:0] upper_bound,
    output logic                   upper_bound_activation,
    output logic                   feasible,
    output logic [COUNT_SIZE-1:0]  active_count
);

    localparam logic [NUMBER_SIZE-1:0] NUM_MIN   = {1'b1, {(NUMBER_SIZE-1){1'b0}}};
    localparam logic [NUMBER_SIZE-1:0] NUM_MAX   = {1'b0, {(NUMBER_SIZE-1){1'b1}}};
    localparam logic [COUNT_SIZE-1:0]  COUNT_MAX = {COUNT_SIZE{1'b1}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t state_q, state_d;

    logic [NUMBER_SIZE-1:0] lowAcc_q, upAcc_q;
    logic                   lowAct_q, upAct_q;
    logic [COUNT_SIZE-1:0]  count_q;

    logic [NUMBER_SIZE-1:0] lowRes_q, upRes_q;
    logic                   lowResAct_q, upResAct_q, feasRes_q;
    logic [COUNT_SIZE-1:0]  countRes_q;

    logic [NUMBER_SIZE-1:0] lowFold_d, upFold_d;
    logic                   lowFoldAct_d, upFoldAct_d, feasFold_d;
    logic [COUNT_SIZE-1:0]  countFold_d;
    logic                   acceptBeat;

    assign acceptBeat = (state_q == ACCUM) && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (in_valid && in_last) state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // in_ready is a pure function of state, so there is no out_ready -> in_ready path.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // Strict comparisons: a tie keeps the value already in the accumulator.
    always_comb begin
        lowFold_d    = lowAcc_q;
        upFold_d     = upAcc_q;
        lowFoldAct_d = lowAct_q | lower_activation;
        upFoldAct_d  = upAct_q | upper_activation;
        countFold_d  = count_q;
        if (lower_activation &&
            (!lowAct_q || ($signed(lower_candidate) > $signed(lowAcc_q)))) begin
            lowFold_d = lower_candidate;
        end
        if (upper_activation &&
            (!upAct_q || ($signed(upper_candidate) < $signed(upAcc_q)))) begin
            upFold_d = upper_candidate;
        end
        if ((lower_activation || upper_activation) && (count_q != COUNT_MAX)) begin
            countFold_d = count_q + COUNT_SIZE'(1);
        end
        feasFold_d = !lowFoldAct_d || !upFoldAct_d ||
                     ($signed(lowFold_d) <= $signed(upFold_d));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lowAcc_q    <= NUM_MIN;
            upAcc_q     <= NUM_MAX;
            lowAct_q    <= 1'b0;
            upAct_q     <= 1'b0;
            count_q     <= '0;
            lowRes_q    <= NUM_MIN;
            upRes_q     <= NUM_MAX;
            lowResAct_q <= 1'b0;
            upResAct_q  <= 1'b0;
            feasRes_q   <= 1'b1;
            countRes_q  <= '0;
        end else if (acceptBeat) begin
            if (in_last) begin
                lowRes_q    <= lowFold_d;
                upRes_q     <= upFold_d;
                lowResAct_q <= lowFoldAct_d;
                upResAct_q  <= upFoldAct_d;
                feasRes_q   <= feasFold_d;
                countRes_q  <= countFold_d;
                lowAcc_q    <= NUM_MIN;
                upAcc_q     <= NUM_MAX;
                lowAct_q    <= 1'b0;
                upAct_q     <= 1'b0;
                count_q     <= '0;
            end else begin
                lowAcc_q    <= lowFold_d;
                upAcc_q     <= upFold_d;
                lowAct_q    <= lowFoldAct_d;
                upAct_q     <= upFoldAct_d;
                count_q     <= countFold_d;
            end
        end
    end

    assign lower_bound            = lowRes_q;
    assign lower_bound_activation = lowResAct_q;
    assign upper_bound            = upRes_q;
    assign upper_bound_activation = upResAct_q;
    assign feasible               = feasRes_q;
    assign active_count           = countRes_q;

endmodule
